// File: rtl/eth_rx_hdr_parser.sv
// rtl/eth_rx_hdr_parser.sv - Ethernet RX header parser: byte stream to header fields plus payload stream
//
// Splits a raw 8-bit Ethernet frame (FCS already removed) into a 14-byte header
// and a payload stream. Unicast frames addressed elsewhere can be filtered out.
// Accepted and dropped frames are counted.
//
// Ports:
//   axis_clk, axis_rst_n        clock, asynchronous active-low reset
//   local_mac                   station MAC used by the unicast filter
//   s_axis_*                    raw frame bytes in (tuser = bad-frame flag with tlast)
//   m_eth_hdr_valid/ready       header handshake
//   m_eth_dest_mac/src_mac/type header fields, stable while hdr_valid is high
//   m_eth_payload_axis_*        payload bytes out, tuser marks a bad frame on the last byte
//   frames_ok, frames_dropped   wrapping frame counters
//   err_runt                    one-cycle pulse per frame shorter than 15 bytes
module eth_rx_hdr_parser #(
    parameter int ENABLE_MAC_FILTER = 1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                 axis_clk,
    input  logic                 axis_rst_n,
    input  logic [47:0]          local_mac,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic                 m_eth_hdr_valid,
    input  logic                 m_eth_hdr_ready,
    output logic [47:0]          m_eth_dest_mac,
    output logic [47:0]          m_eth_src_mac,
    output logic [15:0]          m_eth_type,
    output logic [7:0]           m_eth_payload_axis_tdata,
    output logic                 m_eth_payload_axis_tvalid,
    input  logic                 m_eth_payload_axis_tready,
    output logic                 m_eth_payload_axis_tlast,
    output logic                 m_eth_payload_axis_tuser,
    output logic [CNT_WIDTH-1:0] frames_ok,
    output logic [CNT_WIDTH-1:0] frames_dropped,
    output logic                 err_runt
);

    typedef enum logic [1:0] {
        HDR,
        PAYLOAD,
        DROP
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [103:0]  hdr_sh;      // header bytes 0..12, most recent byte in [7:0]
    logic          run;         // keeps tready low while in reset and for the first cycle after
    logic          s_fire;
    logic [47:0]   dest_now;
    logic [111:0]  hdr_full;
    logic          reject;

    // Destination MAC as it stands when byte 5 is on the input.
    assign dest_now = {hdr_sh[39:0], s_axis_tdata};
    // Complete header as it stands when byte 13 is on the input.
    assign hdr_full = {hdr_sh, s_axis_tdata};
    // Broadcast/multicast (I/G bit set) always passes the filter.
    assign reject   = (ENABLE_MAC_FILTER != 0) && (dest_now != local_mac) && !dest_now[40];

    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            // Only header backpressure: a new header cannot complete while the old one is unaccepted.
            HDR:     s_axis_tready = run && !((cnt == 4'd13) && m_eth_hdr_valid);
            PAYLOAD: s_axis_tready = run && (!m_eth_payload_axis_tvalid || m_eth_payload_axis_tready);
            DROP:    s_axis_tready = run;
            default: s_axis_tready = 1'b0;
        endcase
    end

    assign s_fire = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state                     <= HDR;
            cnt                       <= 4'd0;
            hdr_sh                    <= '0;
            run                       <= 1'b0;
            m_eth_hdr_valid           <= 1'b0;
            m_eth_dest_mac            <= '0;
            m_eth_src_mac             <= '0;
            m_eth_type                <= '0;
            m_eth_payload_axis_tdata  <= '0;
            m_eth_payload_axis_tvalid <= 1'b0;
            m_eth_payload_axis_tlast  <= 1'b0;
            m_eth_payload_axis_tuser  <= 1'b0;
            frames_ok                 <= '0;
            frames_dropped            <= '0;
            err_runt                  <= 1'b0;
        end else begin
            run      <= 1'b1;
            err_runt <= 1'b0;

            if (m_eth_hdr_valid && m_eth_hdr_ready) begin
                m_eth_hdr_valid <= 1'b0;
            end
            // Output register drains independently of the parser state, so the last
            // payload byte can sit here while the next header is being collected.
            if (m_eth_payload_axis_tvalid && m_eth_payload_axis_tready) begin
                m_eth_payload_axis_tvalid <= 1'b0;
            end

            if (s_fire) begin
                case (state)
                    HDR: begin
                        hdr_sh <= {hdr_sh[95:0], s_axis_tdata};
                        if (s_axis_tlast) begin
                            // Runt takes priority over the filter decision on byte 5.
                            err_runt       <= 1'b1;
                            frames_dropped <= frames_dropped + 1'b1;
                            cnt            <= 4'd0;
                        end else if ((cnt == 4'd5) && reject) begin
                            state <= DROP;
                            cnt   <= 4'd0;
                        end else if (cnt == 4'd13) begin
                            m_eth_dest_mac  <= hdr_full[111:64];
                            m_eth_src_mac   <= hdr_full[63:16];
                            m_eth_type      <= hdr_full[15:0];
                            m_eth_hdr_valid <= 1'b1;
                            frames_ok       <= frames_ok + 1'b1;
                            state           <= PAYLOAD;
                            cnt             <= 4'd0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    PAYLOAD: begin
                        m_eth_payload_axis_tdata  <= s_axis_tdata;
                        m_eth_payload_axis_tvalid <= 1'b1;
                        m_eth_payload_axis_tlast  <= s_axis_tlast;
                        m_eth_payload_axis_tuser  <= s_axis_tlast && s_axis_tuser;
                        if (s_axis_tlast) begin
                            state <= HDR;
                            cnt   <= 4'd0;
                        end
                    end
                    DROP: begin
                        if (s_axis_tlast) begin
                            state          <= HDR;
                            frames_dropped <= frames_dropped + 1'b1;
                        end
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

endmodule

// File: doc/eth_rx_hdr_parser.md
Name: eth_rx_hdr_parser

Overview:
- Sits between the 32→8 RX width converter and the UDP/IP stack's Ethernet input.
- Parses raw 8-bit frame bytes (first byte = first dest MAC octet, FCS already stripped by the MAC) into the stack's Ethernet header interface plus a payload stream.
- Optionally drops frames not addressed to the local MAC; counts accepted and dropped frames.

Parameters:
- ENABLE_MAC_FILTER, 1: 1 = drop frames that are unicast to a MAC other than local_mac; 0 = accept all.
- CNT_WIDTH, 16: width of the status counters.

Ports:
- axis_clk  in  1  clock
- axis_rst_n  in  1  asynchronous active-low reset
- local_mac  in  48  station MAC, quasi-static
- s_axis_tdata  in  8  raw frame byte
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  byte accepted
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  1  bad-frame flag, sampled with tlast
- m_eth_hdr_valid  out  1  header valid
- m_eth_hdr_ready  in  1  header accepted
- m_eth_dest_mac  out  48  frame bytes 0-5, byte 0 in [47:40]
- m_eth_src_mac  out  48  frame bytes 6-11, byte 6 in [47:40]
- m_eth_type  out  16  frame bytes 12-13, byte 12 in [15:8]
- m_eth_payload_axis_tdata  out  8  payload byte
- m_eth_payload_axis_tvalid  out  1  payload valid
- m_eth_payload_axis_tready  in  1  payload accepted
- m_eth_payload_axis_tlast  out  1  last payload byte
- m_eth_payload_axis_tuser  out  1  copy of s_axis_tuser on the last byte
- frames_ok  out  CNT_WIDTH  count of headers handed off; wraps
- frames_dropped  out  CNT_WIDTH  count of filtered and runt frames; wraps
- err_runt  out  1  one-cycle pulse when a frame is shorter than 15 bytes

Behaviour:
- Reset: asynchronous assert, synchronous deassert handled upstream.
  - All outputs are 0: valid/tlast/tuser/tready/counters/err_runt and header fields.
  - State goes to HDR; byte counter = 0.
- A byte is transferred only when tvalid and tready are both high. The byte counter (0..13) counts transferred bytes only.
- State HDR:
  - s_axis_tready = 1, except it is held 0 when the byte about to be accepted is byte 13 and m_eth_hdr_valid is still 1 from the previous frame. This is the only header backpressure.
  - Bytes 0-13 shift into shadow registers.
  - At byte 5, the filter check is made. If ENABLE_MAC_FILTER=1 and dest_mac != local_mac and dest_mac[40]=0 (unicast), the frame is rejected: go to DROP, and frames_dropped increments when the frame's tlast is seen.
  - Broadcast and multicast (dest_mac[40]=1) are always accepted.
  - tlast on any byte 0-13: the frame is a runt. Pulse err_runt, increment frames_dropped, no header is emitted, counter resets to 0, stay in HDR.
  - Byte 13 accepted without tlast: copy the shadow registers to the m_eth_* fields, set m_eth_hdr_valid the next cycle, increment frames_ok, go to PAYLOAD.
- Header handshake:
  - m_eth_hdr_valid stays 1 and the m_eth_* fields are stable until m_eth_hdr_ready=1, then valid clears.
  - Header and payload handshakes are independent; payload may flow before the header is accepted.
- State PAYLOAD:
  - The payload path is a one-entry output register with 1-cycle latency.
  - s_axis_tready = !m_tvalid_reg || m_eth_payload_axis_tready, giving full throughput with ready held high.
  - tdata, tlast and tuser are registered together.
  - On the transfer of an input byte with tlast: go to HDR, counter = 0.
  - The next frame's header bytes may be accepted while the final payload byte is still held in the output register.
- State DROP: s_axis_tready = 1, bytes are discarded, outputs are unaffected. On tlast: go to HDR and increment frames_dropped.
- Simultaneous events: if frames_ok/frames_dropped increments coincide with a wrap, wrap to 0. err_runt and the drop increment happen in the same cycle.
- Changing local_mac mid-frame affects only frames whose byte 5 arrives after the change.
- Reset mid-frame: the partial frame is lost; the first byte after reset is treated as byte 0.

Test Plan:
- 64-byte frame, dest=local_mac 02:00:00:00:00:01, type 0x0800, payload bytes 0x00..0x31, hdr_ready and tready held 1 → header dest=0x020000000001, type=0x0800; 50 payload bytes in order with tlast on 0x31; frames_ok=1; zero bubbles.
- Unicast dest 02:00:00:00:00:99 with filter on → no header, no payload, s_axis_tready stays 1, frames_dropped=1. Broadcast FF:FF:FF:FF:FF:FF → accepted, frames_ok increments.
- 10-byte frame with tlast on byte 9, then a 14-byte frame → err_runt pulses once per frame, frames_dropped=2, m_eth_hdr_valid never asserts.
- Back-to-back 20-byte frames with m_eth_hdr_ready held 0 → second frame stalls with s_axis_tready=0 at its byte 13. Raising hdr_ready releases it; both headers are delivered in order with correct fields.
- Random 0/1 toggling of m_eth_payload_axis_tready and s_axis_tvalid over 100 frames → payload matches a scoreboard byte-exactly; tuser=1 injected on frame 7's last byte appears only on its last payload byte.
- axis_rst_n pulsed low at payload byte 20 of a frame → all outputs 0 immediately; the next complete frame parses correctly; counters restart from 0.
